data_read_controller: RTL and testbench

DATA_READ_CONTROLLER -- requirements
Module: data_read_controller

---
 rtl/data_read_controller_if.sv | 20 ++
 rtl/data_read_controller.sv | 193 +++++++++++++++++++
 tb/tb_data_read_controller.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_read_controller_if.sv
// rtl/data_read_controller_if.sv - RAM read port and byte transmit stream of data_read_controller.
// master: controller side; slave: RAM/transmitter side.
interface data_read_controller_if;
  logic        ram_rd_en;
  logic [10:0] ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output ram_rd_en, ram_rd_addr, tx_data, tx_valid,
    input  ram_rd_data, tx_ready
  );

  modport slave (
    input  ram_rd_en, ram_rd_addr, tx_data, tx_valid,
    output ram_rd_data, tx_ready
  );
endinterface

// File: rtl/data_read_controller.sv
// rtl/data_read_controller.sv - reads signed int32 words from RAM and streams them as ASCII decimal.
// Optional macro READ_EOL_EN: append CR LF after the last word of every pass.
module data_read_controller (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [10:0]                   total_count,
  data_read_controller_if.master        bus,
  output logic                          busy,
  output logic [10:0]                   read_count,
  output logic                          done
);

`ifdef READ_EOL_EN
  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_WAIT, S_LOAD, S_CONV, S_SIGN, S_DIGIT, S_SEP, S_EOL, S_DONE
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_WAIT, S_LOAD, S_CONV, S_SIGN, S_DIGIT, S_SEP, S_DONE
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next;

  logic [10:0] r_total;
  logic [10:0] r_count;
  logic [10:0] r_addr;
  logic [31:0] r_word;
  logic        r_neg;
  logic [31:0] r_mag;
  logic [3:0]  r_stack [0:9];
  logic [3:0]  r_depth;
`ifdef READ_EOL_EN
  logic        r_eol_lf;
`endif

  logic        w_fire;
  logic        w_last_word;
  logic [31:0] w_mag_div;
  logic [3:0]  w_digit;
  logic [3:0]  w_top;

  assign w_fire      = bus.tx_valid && bus.tx_ready;
  assign w_last_word = ({1'b0, r_count} + 12'd1) >= {1'b0, r_total};
  assign w_mag_div   = r_mag / 32'd10;
  assign w_digit     = 4'(r_mag % 32'd10);
  assign w_top       = r_stack[r_depth - 4'd1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef READ_EOL_EN
          w_next = (total_count == 11'd0) ? S_EOL : S_READ;
`else
          w_next = (total_count == 11'd0) ? S_DONE : S_READ;
`endif
        end
      end
      S_READ: w_next = S_WAIT;
      S_WAIT: w_next = S_LOAD;
      S_LOAD: w_next = S_CONV;
      S_CONV: begin
        // A negative word spends a cycle on '-'; a positive one goes straight to digits.
        if (w_mag_div == 32'd0) w_next = r_neg ? S_SIGN : S_DIGIT;
      end
      S_SIGN: begin
        if (w_fire) w_next = S_DIGIT;
      end
      S_DIGIT: begin
        if (w_fire && r_depth == 4'd1) begin
`ifdef READ_EOL_EN
          w_next = w_last_word ? S_EOL : S_SEP;
`else
          w_next = w_last_word ? S_DONE : S_SEP;
`endif
        end
      end
      S_SEP: begin
        if (w_fire) w_next = S_READ;
      end
`ifdef READ_EOL_EN
      S_EOL: begin
        if (w_fire && r_eol_lf) w_next = S_DONE;
      end
`endif
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ram_rd_en   = 1'b0;
    bus.ram_rd_addr = r_addr;
    bus.tx_valid    = 1'b0;
    bus.tx_data     = 8'h00;
    done            = 1'b0;
    busy            = (r_state != S_IDLE);
    read_count      = r_count;
    case (r_state)
      S_READ:  bus.ram_rd_en = 1'b1;
      S_SIGN: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h2D;
      end
      S_DIGIT: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h30 + {4'h0, w_top};
      end
      S_SEP: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h20;
      end
`ifdef READ_EOL_EN
      S_EOL: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = r_eol_lf ? 8'h0A : 8'h0D;
      end
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_total <= '0;
      r_count <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      r_neg   <= 1'b0;
      r_mag   <= '0;
      r_depth <= '0;
      for (int i = 0; i < 10; i++) r_stack[i] <= '0;
`ifdef READ_EOL_EN
      r_eol_lf <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_total <= total_count;
            r_count <= '0;
            r_addr  <= '0;
            r_depth <= '0;
`ifdef READ_EOL_EN
            r_eol_lf <= 1'b0;
`endif
          end
        end
        // The RAM word is only valid during WAIT, so it is held for LOAD to decode.
        S_WAIT: r_word <= bus.ram_rd_data;
        S_LOAD: begin
          r_neg   <= r_word[31];
          r_mag   <= r_word[31] ? (~r_word + 32'd1) : r_word;
          r_depth <= '0;
        end
        S_CONV: begin
          r_stack[r_depth] <= w_digit;
          r_depth          <= r_depth + 4'd1;
          r_mag            <= w_mag_div;
        end
        S_DIGIT: begin
          if (w_fire) begin
            r_depth <= r_depth - 4'd1;
            if (r_depth == 4'd1) r_count <= r_count + 11'd1;
          end
        end
        S_SEP: begin
          if (w_fire) r_addr <= r_addr + 11'd1;
        end
`ifdef READ_EOL_EN
        S_EOL: begin
          if (w_fire) r_eol_lf <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_read_controller.sv
// tb/tb_data_read_controller.sv - randomized self-checking bench for data_read_controller.
// Expected text is built from the RAM contents with %0d formatting.
module tb_data_read_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] total_count;
  logic        busy;
  logic [10:0] read_count;
  logic        done;

  data_read_controller_if bus();

  data_read_controller dut (
    .clk(clk), .rst(rst), .start(start), .total_count(total_count),
    .bus(bus), .busy(busy), .read_count(read_count), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:2047];
  int ready_pct = 100;

  always @(posedge clk) bus.ram_rd_data <= bus.ram_rd_en ? mem[bus.ram_rd_addr] : $urandom;

  always @(posedge clk) begin
    #1;
    bus.tx_ready = (int'($urandom_range(99)) < ready_pct);
  end

  byte unsigned q_bytes[$];
  int q_addr[$];
  int n_ren, n_done, n_stab;
  logic p_valid = 1'b0, p_ready = 1'b0;
  logic [7:0] p_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      p_valid = 1'b0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) q_bytes.push_back(bus.tx_data);
      if (bus.ram_rd_en) begin
        n_ren++;
        q_addr.push_back(int'(bus.ram_rd_addr));
      end
      if (done) n_done++;
      if (p_valid && !p_ready && (!bus.tx_valid || bus.tx_data !== p_data)) n_stab++;
      p_valid = bus.tx_valid;
      p_ready = bus.tx_ready;
      p_data  = bus.tx_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    q_bytes.delete();
    q_addr.delete();
    n_ren = 0;
    n_done = 0;
    n_stab = 0;
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    total_count = 11'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #2;
  endtask

  function automatic string expected_str(input int n);
    string s = "";
    for (int i = 0; i < n; i++) begin
      s = {s, $sformatf("%0d", $signed(mem[i]))};
      if (i < n - 1) s = {s, " "};
    end
`ifdef READ_EOL_EN
    s = {s, "\r\n"};
`endif
    return s;
  endfunction

  function automatic string got_str();
    string s = "";
    foreach (q_bytes[i]) s = {s, $sformatf("%c", q_bytes[i])};
    return s;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(3))
      0: return 32'($urandom_range(20)) - 32'd10;
      1: return $urandom;
      2: begin
        case ($urandom_range(2))
          0: return 32'h8000_0000;
          1: return 32'h7FFF_FFFF;
          default: return 32'h0;
        endcase
      end
      default: return 32'd0 - 32'($urandom_range(999999));
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    total_count = '0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (bus.ram_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %b want 0", bus.ram_rd_en); end
    n_cmp++; if (bus.ram_rd_addr !== 11'd0) begin n_err++; $display("FAIL reset_rd_addr got %0d want 0", bus.ram_rd_addr); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
    n_cmp++; if (read_count !== 11'd0) begin n_err++; $display("FAIL reset_read_count got %0d want 0", read_count); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; bit ok; string exp, got;
    mem[0] = 32'd5; mem[1] = -32'sd12; mem[2] = 32'd0;
    ready_pct = 100;
    clear_mon();
    pulse_start(3);
    wait_done(cyc, ok);
    exp = expected_str(3); got = got_str();
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout got no done want done"); end
    n_cmp++; if (got != exp) begin n_err++; $display("FAIL basic_bytes got \"%s\" want \"%s\"", got, exp); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL basic_done_pulses got %0d want 1", n_done); end
    n_cmp++; if (read_count !== 11'd3) begin n_err++; $display("FAIL basic_read_count got %0d want 3", read_count); end
    n_cmp++; if (n_ren !== 3) begin n_err++; $display("FAIL basic_rd_pulses got %0d want 3", n_ren); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_extremes();
    int cyc; bit ok; string exp, got;
    mem[0] = 32'h8000_0000; mem[1] = 32'h7FFF_FFFF;
    ready_pct = 100;
    clear_mon();
    pulse_start(2);
    wait_done(cyc, ok);
    exp = expected_str(2); got = got_str();
    n_cmp++; if (!ok || got != exp) begin n_err++; $display("FAIL extremes_bytes got \"%s\" want \"%s\"", got, exp); end
    n_cmp++; if (q_addr.size() != 2 || q_addr[0] != 0 || q_addr[1] != 1) begin n_err++; $display("FAIL extremes_addrs got %p want 0,1", q_addr); end
  endtask

  task automatic test_zero();
    int cyc; bit ok; string exp, got;
    ready_pct = 100;
    clear_mon();
    pulse_start(0);
    wait_done(cyc, ok);
    exp = expected_str(0); got = got_str();
    n_cmp++; if (!ok || cyc < 1 || cyc > 3) begin n_err++; $display("FAIL zero_done_latency got %0d cycles want 1..3", cyc); end
    n_cmp++; if (n_ren !== 0) begin n_err++; $display("FAIL zero_rd_pulses got %0d want 0", n_ren); end
    n_cmp++; if (got != exp) begin n_err++; $display("FAIL zero_bytes got %0d bytes want %0d", got.len(), exp.len()); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL zero_done_pulses got %0d want 1", n_done); end
  endtask

  task automatic test_backpressure();
    int cyc; bit ok; string exp, got;
    mem[0] = 32'd123;
    ready_pct = 30;
    clear_mon();
    pulse_start(1);
    wait_done(cyc, ok);
    ready_pct = 100;
    exp = expected_str(1); got = got_str();
    n_cmp++; if (!ok || got != exp) begin n_err++; $display("FAIL bp_bytes got \"%s\" want \"%s\"", got, exp); end
    n_cmp++; if (n_stab !== 0) begin n_err++; $display("FAIL bp_stable got %0d violations want 0", n_stab); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL bp_done_pulses got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok, seen; string exp, got;
    mem[0] = 32'd1234567 + 32'($urandom_range(1000));
    for (int i = 1; i < 5; i++) mem[i] = rand_word();
    ready_pct = 100;
    clear_mon();
    pulse_start(5);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q_bytes.size() >= 4 && bus.tx_valid) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rstmid_reach got %0d bytes want >=4", q_bytes.size()); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #2;
    n_cmp++;
    if ({bus.ram_rd_en, bus.ram_rd_addr, bus.tx_data, bus.tx_valid, busy, read_count, done} !== 34'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs got en=%b addr=%0d data=%h valid=%b busy=%b rc=%0d done=%b want all 0",
               bus.ram_rd_en, bus.ram_rd_addr, bus.tx_data, bus.tx_valid, busy, read_count, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem[0] = 32'd42; mem[1] = -32'sd7;
    clear_mon();
    pulse_start(2);
    wait_done(cyc, ok);
    exp = expected_str(2); got = got_str();
    n_cmp++; if (!ok || got != exp) begin n_err++; $display("FAIL rstmid_restart_bytes got \"%s\" want \"%s\"", got, exp); end
    n_cmp++; if (q_addr.size() != 2 || q_addr[0] != 0) begin n_err++; $display("FAIL rstmid_restart_addr got %p want 0,1", q_addr); end
  endtask

  task automatic test_start_repeat();
    bit ok; string exp, got;
    for (int i = 0; i < 3; i++) mem[i] = rand_word();
    ready_pct = 100;
    clear_mon();
    pulse_start(3);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      start = (i % 3 == 0);
      total_count = 11'($urandom_range(2047));
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    exp = expected_str(3); got = got_str();
    n_cmp++; if (!ok || got != exp) begin n_err++; $display("FAIL restart_bytes got \"%s\" want \"%s\"", got, exp); end
    n_cmp++; if (n_done !== 1 || n_ren !== 3) begin n_err++; $display("FAIL restart_counts got done=%0d rd=%0d want 1,3", n_done, n_ren); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL restart_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    int cyc, n; bit ok, addr_ok; string exp, got;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) mem[i] = rand_word();
      ready_pct = $urandom_range(40, 100);
      clear_mon();
      pulse_start(n);
      wait_done(cyc, ok);
      exp = expected_str(n); got = got_str();
      addr_ok = (q_addr.size() == n);
      foreach (q_addr[i]) if (q_addr[i] != i) addr_ok = 1'b0;
      n_cmp++; if (!ok || got != exp) begin n_err++; $display("FAIL random%0d_bytes got \"%s\" want \"%s\"", r, got, exp); end
      n_cmp++; if (!addr_ok) begin n_err++; $display("FAIL random%0d_addrs got %p want 0..%0d", r, q_addr, n - 1); end
      n_cmp++; if (read_count !== 11'(n) || n_stab !== 0) begin n_err++; $display("FAIL random%0d_count_stable got rc=%0d stab=%0d want %0d,0", r, read_count, n_stab, n); end
    end
    ready_pct = 100;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_start_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
